// File: rtl/conv_col_feeder.sv
// Purpose : turns a raster pixel stream into vertical 3-pixel columns (rows r-2, r-1, r)
//           for the conv/relu/pool unit, buffering the two previous rows on chip.
// Latency : 1 cycle from an accepted STREAM pixel to its column; frame_done 1 cycle after the last column.
// Backpressure: plain valid/ready on the input; no transfer means no state change and no enable pulse.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start             : one-cycle pulse, begins a frame only while idle
//   in_valid/in_ready : source handshake; in_pix is the raster-order pixel
//   out_col           : {row r-2, row r-1, row r} of column c, valid when enable=1
//   num_block_change  : set with enable on the first column (c==0) of each row-triple
//   frame_done        : one-cycle pulse in the cycle after the final enable
module conv_col_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pix,
  output logic [3*PIX_W-1:0] out_col,
  output logic               enable,
  output logic               num_block_change,
  output logic               frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [PIX_W-1:0] lb0 [IMG_W];  // row r-2
  logic [PIX_W-1:0] lb1 [IMG_W];  // row r-1
  logic            xfer;
  logic            col_end;

  assign xfer    = in_valid && in_ready;
  assign col_end = (col == COL_LAST);

  // Next-state and handshake decode. in_valid is used directly (rather than
  // xfer) so that in_ready is not fed back into its own process.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && col_end && (row == ROW_ONE)) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && col_end && (row == ROW_LAST)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      col              <= '0;
      row              <= '0;
      out_col          <= '0;
      enable           <= 1'b0;
      num_block_change <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      state            <= state_nxt;
      enable           <= 1'b0;
      num_block_change <= 1'b0;
      // Registered off the DONE state so the pulse trails the final enable
      // by exactly one cycle instead of coinciding with it.
      frame_done       <= (state == S_DONE);
      if (xfer) begin
        // Counters wrap to zero on the last pixel, so DONE finds them cleared.
        if (col_end) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
        end else begin
          col <= col + COL_ONE;
        end
        if (state == S_STREAM) begin
          out_col          <= {lb0[col], lb1[col], in_pix};
          enable           <= 1'b1;
          num_block_change <= (col == '0);
        end
      end
    end
  end

  // Line buffers shift one row per column slot; reads above see pre-write data.
  // No reset: every entry is rewritten during FILL before it can be emitted.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_pix;
    end
  end

endmodule

// File: tb/tb_conv_col_feeder.sv
module tb_conv_col_feeder;

  localparam int PW = 16;

  typedef struct packed {
    logic [3*PW-1:0] col;
    logic            nbc;
    logic [31:0]     cyc;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic            s_start = 1'b0, s_valid = 1'b0;
  logic            s_ready, s_en, s_nbc, s_done;
  logic [PW-1:0]   s_pix = '0;
  logic [3*PW-1:0] s_col;

  logic            l_start = 1'b0, l_valid = 1'b0;
  logic            l_ready, l_en, l_nbc, l_done;
  logic [PW-1:0]   l_pix = '0;
  logic [3*PW-1:0] l_col;

  conv_col_feeder #(.IMG_W(4), .IMG_H(4), .PIX_W(PW)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_pix(s_pix), .out_col(s_col), .enable(s_en), .num_block_change(s_nbc),
    .frame_done(s_done)
  );

  conv_col_feeder #(.IMG_W(28), .IMG_H(28), .PIX_W(PW)) dut_l (
    .clk(clk), .rst(rst), .start(l_start), .in_valid(l_valid), .in_ready(l_ready),
    .in_pix(l_pix), .out_col(l_col), .enable(l_en), .num_block_change(l_nbc),
    .frame_done(l_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors: every enable and frame_done with the cycle it was seen.
  ev_t s_evq[$];
  ev_t l_evq[$];
  int  s_doneq[$];
  int  l_doneq[$];
  always @(negedge clk) begin
    if (s_en === 1'b1) s_evq.push_back({s_col, s_nbc, 32'(cyc)});
    if (s_done === 1'b1) s_doneq.push_back(cyc);
    if (l_en === 1'b1) l_evq.push_back({l_col, l_nbc, 32'(cyc)});
    if (l_done === 1'b1) l_doneq.push_back(cyc);
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference image and expected column stream derived from it.
  logic [PW-1:0] img[$];
  ev_t           exp_q[$];
  int            last_acc;

  task automatic set_in(input bit big, input logic st, input logic v, input logic [PW-1:0] p);
    if (big) begin
      l_start = st; l_valid = v; l_pix = p;
    end else begin
      s_start = st; s_valid = v; s_pix = p;
    end
  endtask

  // mode 0: continuous valid, 1: valid pattern 1,0,0, 2: random valid.
  // Expected columns come straight from the image: {img[r-2][c], img[r-1][c], img[r][c]},
  // seen one cycle after the accepting edge.
  task automatic drive_frame(input string tag, input bit big, input int w, input int h,
                             input int mode, input int stop_after, input int poke);
    int  k = 0;
    int  slot = 0;
    int  guard = 0;
    bit  v;
    bit  rdy;
    bit  poked = 0;
    logic st;
    exp_q.delete();
    if (big) begin
      l_evq.delete(); l_doneq.delete();
    end else begin
      s_evq.delete(); s_doneq.delete();
    end
    @(negedge clk);
    set_in(big, 1'b1, 1'b0, '0);
    @(negedge clk);
    while (k < stop_after && guard < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (slot % 3 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      st = (k == poke) && !poked;
      if (st) poked = 1'b1;
      set_in(big, st, v, img[k]);
      rdy = big ? l_ready : s_ready;
      if (v && rdy) begin
        int r;
        int c;
        r = k / w;
        c = k % w;
        if (r >= 2) exp_q.push_back({img[k-2*w], img[k-w], img[k], (c == 0), 32'(cyc + 1)});
        last_acc = cyc + 1;
        k++;
      end
      slot++;
      guard++;
      @(negedge clk);
    end
    set_in(big, 1'b0, 1'b0, '0);
    chk($sformatf("%s_pixels_accepted", tag), 64'(k), 64'(stop_after));
    if (h < 3) chk($sformatf("%s_height", tag), 64'(h), 64'(3));
  endtask

  task automatic check_frame(input string tag, input bit big, input int exp_done);
    ev_t obs[$];
    int  dq[$];
    if (big) begin
      obs = l_evq; dq = l_doneq;
    end else begin
      obs = s_evq; dq = s_doneq;
    end
    chk($sformatf("%s_enable_count", tag), 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      chk($sformatf("%s_col[%0d]", tag, i), 64'(obs[i].col), 64'(exp_q[i].col));
      chk($sformatf("%s_nbc[%0d]", tag, i), 64'(obs[i].nbc), 64'(exp_q[i].nbc));
      chk($sformatf("%s_cyc[%0d]", tag, i), 64'(obs[i].cyc), 64'(exp_q[i].cyc));
    end
    chk($sformatf("%s_done_count", tag), 64'(dq.size()), 64'(exp_done));
    if (exp_done == 1 && dq.size() == 1)
      chk($sformatf("%s_done_cycle", tag), 64'(dq[0]), 64'(last_acc + 1));
  endtask

  initial begin
    int nbc_cnt;

    // Reset with in_valid held high.
    s_valid = 1'b1; s_pix = 16'h0007;
    l_valid = 1'b1; l_pix = 16'h0007;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(s_ready), 64'(0));
    chk("rst_enable", 64'(s_en), 64'(0));
    chk("rst_out_col", 64'(s_col), 64'(0));
    chk("rst_frame_done", 64'(s_done), 64'(0));
    chk("rst_l_in_ready", 64'(l_ready), 64'(0));
    rst = 1'b0;

    // in_valid while idle is ignored.
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(s_ready), 64'(0));
      chk("idle_enable", 64'(s_en), 64'(0));
    end
    s_valid = 1'b0; l_valid = 1'b0;

    // Small frame, continuous stream 1..16.
    img.delete();
    for (int i = 1; i <= 16; i++) img.push_back(16'(i));
    drive_frame("cont", 1'b0, 4, 4, 0, 16, -1);
    repeat (5) @(negedge clk);
    check_frame("cont", 1'b0, 1);
    chk("cont_total_enables", 64'(s_evq.size()), 64'(8));
    if (s_evq.size() == 8) begin
      chk("cont_first_col", 64'(s_evq[0].col), {16'd0, 16'd1, 16'd5, 16'd9});
      chk("cont_first_nbc", 64'(s_evq[0].nbc), 64'(1));
      chk("cont_row3_col", 64'(s_evq[4].col), {16'd0, 16'd5, 16'd9, 16'd13});
      chk("cont_row3_nbc", 64'(s_evq[4].nbc), 64'(1));
      chk("cont_last_col", 64'(s_evq[7].col), {16'd0, 16'd8, 16'd12, 16'd16});
      chk("cont_back_to_back", 64'(s_evq[7].cyc - s_evq[0].cyc), 64'(7));
    end
    chk("cont_col_hold", 64'(s_col), {16'd0, 16'd8, 16'd12, 16'd16});
    chk("cont_idle_ready", 64'(s_ready), 64'(0));

    // Same image with gapped valid.
    drive_frame("gap", 1'b0, 4, 4, 1, 16, -1);
    repeat (5) @(negedge clk);
    check_frame("gap", 1'b0, 1);

    // Abort after pixel 11, then a fresh frame 101..116.
    drive_frame("abort", 1'b0, 4, 4, 0, 11, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rst_out_col", 64'(s_col), 64'(0));
    repeat (6) @(negedge clk);
    check_frame("abort", 1'b0, 0);
    img.delete();
    for (int i = 101; i <= 116; i++) img.push_back(16'(i));
    drive_frame("restart", 1'b0, 4, 4, 0, 16, -1);
    repeat (5) @(negedge clk);
    check_frame("restart", 1'b0, 1);
    if (s_evq.size() > 0)
      chk("restart_first_col", 64'(s_evq[0].col), {16'd0, 16'd101, 16'd105, 16'd109});

    // Max-size random frame, random valid, stray start during STREAM.
    img.delete();
    for (int i = 0; i < 28 * 28; i++) img.push_back(16'($urandom));
    drive_frame("big", 1'b1, 28, 28, 2, 28 * 28, 300);
    repeat (5) @(negedge clk);
    check_frame("big", 1'b1, 1);
    nbc_cnt = 0;
    foreach (l_evq[i]) if (l_evq[i].nbc) nbc_cnt++;
    chk("big_enables", 64'(l_evq.size()), 64'(728));
    chk("big_nbc_pulses", 64'(nbc_cnt), 64'(26));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_col_feeder.md
Name: conv_col_feeder

Overview:
- Producer side of the 48-bit column interface consumed by the conv/relu/pool unit.
- Accepts a raster-order stream of 16-bit pixels and buffers two previous rows in line buffers.
- Emits vertical 3-pixel columns (rows r-2, r-1, r) with enable and num_block_change, so the unit can build 3x3 windows.
- Sits between the image source (BRAM reader / input FIFO) and the unit.

Parameters:
- IMG_W, 28, pixels per row (>=3).
- IMG_H, 28, rows per frame (>=3).
- PIX_W, 16, bits per pixel; the output column is 3*PIX_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise.
- in_valid  in  1  source pixel valid.
- in_ready  out  1  feeder can accept a pixel.
- in_pix  in  PIX_W  source pixel, raster order.
- out_col  out  3*PIX_W  [47:32]=row r-2, [31:16]=row r-1, [15:0]=row r, same column c.
- enable  out  1  out_col valid this cycle.
- num_block_change  out  1  first column of a new row-triple (c==0, r>=2).
- frame_done  out  1  one-cycle pulse after the last pixel's column is emitted.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_col=0, enable=0, num_block_change=0, frame_done=0, in_ready=0. col/row counters=0, state=IDLE. Line-buffer contents are don't-care; they are never emitted before being overwritten.
- States:
  - IDLE: in_ready=0. On start, go to FILL.
  - FILL (rows 0-1): in_ready=1. Accepted pixels are written to the line buffers only; enable stays 0. After pixel (1, IMG_W-1), go to STREAM.
  - STREAM (rows 2..IMG_H-1): in_ready=1. Each accepted pixel produces one output column.
  - DONE: single cycle, in_ready=0, frame_done=1, counters cleared. Then go to IDLE.
- Accept rule: a pixel transfers when in_valid && in_ready. With no transfer, counters, buffers and state hold, and enable/num_block_change are 0 the next cycle (outputs are pulse-per-transfer).
- Line buffers:
  - Two arrays lb0 (row r-2) and lb1 (row r-1), IMG_W entries each, indexed by col.
  - On transfer at (r,c): read lb0[c] and lb1[c], then write lb0[c]<=lb1[c] and lb1[c]<=in_pix in the same cycle.
  - Reads use pre-write values.
- Output timing:
  - Latency is 1 cycle: at the edge after a STREAM transfer at (r,c), out_col={lb0[c], lb1[c], in_pix} and enable=1.
  - num_block_change=1 in that same cycle iff c==0.
  - out_col holds its last value when enable=0.
- Counters:
  - col wraps IMG_W-1 -> 0 and increments row.
  - When the transfer at (IMG_H-1, IMG_W-1) occurs, go to DONE. frame_done is asserted in the cycle after the final enable, so it lags the last transfer by 2 cycles.
- Full-rate operation: in_valid held high gives back-to-back enables with no bubbles, including across row boundaries.
- start while not IDLE: ignored.
- rst asserted mid-frame: next edge forces all reset values. A partially emitted frame is abandoned and no frame_done is produced. The next start begins with FILL (two new rows).
- in_valid while IDLE or DONE: not accepted (in_ready=0), no counter change.

Test Plan:
- Reset check: IMG_W=4, IMG_H=4; drive rst for 2 cycles with in_valid=1 -> in_ready=0, enable=0, out_col=0, frame_done=0.
- Fill phase: start, then stream pixels 1..16 continuously:
  - No enable during pixels 1..8.
  - First enable carries out_col={1,5,9} with num_block_change=1.
  - Next enables carry {2,6,10}, {3,7,11}, {4,8,12}.
- Row boundary and end of frame, same stream:
  - enable for {5,9,13} has num_block_change=1.
  - Final column {8,12,16}.
  - frame_done pulses exactly 1 cycle after that enable.
  - Total enables = 8.
- Backpressure gaps: same image with in_valid toggling 1,0,0,1,...:
  - Identical out_col sequence, with enables only one cycle after each accepted pixel.
  - num_block_change only on c==0 columns.
- Mid-frame reset: assert rst after pixel 11, then start again and send values 101..116:
  - No frame_done for the aborted frame.
  - First enable is {101,105,109}; no stale values 1..11 appear.
- Ignored start and max-size frame:
  - Pulse start during STREAM -> no effect.
  - IMG_W=28, IMG_H=28 random pixels checked against a reference model -> 728 enables and 26 num_block_change pulses.
